blackjack_engine: RTL and testbench

BLACKJACK_ENGINE -- requirements
Module: blackjack_engine

---
 rtl/blackjack_engine.sv | 176 +++++++++++++++++
 tb/tb_blackjack_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_engine.sv
// Blackjack game engine: deals two cards each, runs the player turn, then draws for the dealer.
// Soft aces are counted only when SOFT_ACE_EN is defined. A card is consumed on any edge where it is accepted; otherwise the state waits.
module blackjack_engine #(
  parameter int CARD_W       = 4,
  parameter int SUM_W        = 6,
  parameter int TARGET       = 21,
  parameter int DEALER_STAND = 17,
  parameter int CARD_MAX     = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hit,
  input  logic              stay,
  input  logic [CARD_W-1:0] card,
  output logic              dhit,
  output logic              dstay,
  output logic              win,
  output logic              lose,
  output logic              tie,
  output logic [SUM_W-1:0]  player_sum,
  output logic [SUM_W-1:0]  dealer_sum
);

  localparam int EW = SUM_W + 1;
  localparam logic [EW-1:0] TGT   = EW'(TARGET);
  localparam logic [EW-1:0] STAND = EW'(DEALER_STAND);
  localparam logic [EW-1:0] SMAX  = EW'((1 << SUM_W) - 1);
  localparam logic [EW-1:0] CMAX  = EW'(CARD_MAX);

  generate
    if ((TARGET + CARD_MAX > (1 << SUM_W) - 1) || (DEALER_STAND > TARGET)) begin : g_param_check
      $error("blackjack_engine: SUM_W too narrow for TARGET+CARD_MAX, or DEALER_STAND > TARGET");
    end
  endgenerate

  typedef enum logic [3:0] {
    DEAL_P0, DEAL_D0, DEAL_P1, DEAL_D1, CHECK, PLAYER, D_EVAL, D_REQ, DONE
  } state_t;

  state_t              state, state_nxt;
  logic                p_load, d_load;
  logic                set_win, set_lose, set_tie;
  logic                card_ok;
  logic [EW-1:0]       card_e, p_e, d_e;
  logic [SUM_W-1:0]    p_add, d_add;

  assign card_ok = (card != '0);
  assign card_e  = (EW'(card) > CMAX) ? CMAX : EW'(card);
  assign p_e     = EW'(player_sum);
  assign d_e     = EW'(dealer_sum);

  // Sums are computed one bit wider so the saturation compare sees the carry.
  function automatic logic [SUM_W-1:0] sat(input logic [EW-1:0] v);
    return (v > SMAX) ? SMAX[SUM_W-1:0] : v[SUM_W-1:0];
  endfunction

`ifdef SOFT_ACE_EN
  logic p_soft, d_soft, p_soft_nxt, d_soft_nxt;

  function automatic logic [SUM_W-1:0] add_soft(input  logic [EW-1:0] sum,
                                                input  logic [EW-1:0] cv,
                                                input  logic          soft_in,
                                                output logic          soft_out);
    logic [EW-1:0] t;
    logic          s;
    s = soft_in;
    if (cv == EW'(1) && sum + EW'(11) <= TGT) begin
      t = sum + EW'(11);
      s = 1'b1;
    end else begin
      t = sum + cv;
    end
    if (s && t > TGT) begin
      t = t - EW'(10);
      s = 1'b0;
    end
    soft_out = s;
    return sat(t);
  endfunction

  always_comb begin
    p_add = add_soft(p_e, card_e, p_soft, p_soft_nxt);
    d_add = add_soft(d_e, card_e, d_soft, d_soft_nxt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_soft <= 1'b0;
      d_soft <= 1'b0;
    end else begin
      if (p_load) p_soft <= p_soft_nxt;
      if (d_load) d_soft <= d_soft_nxt;
    end
  end
`else
  always_comb begin
    p_add = sat(p_e + card_e);
    d_add = sat(d_e + card_e);
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= DEAL_P0;
      player_sum <= '0;
      dealer_sum <= '0;
      win        <= 1'b0;
      lose       <= 1'b0;
      tie        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (p_load)   player_sum <= p_add;
      if (d_load)   dealer_sum <= d_add;
      if (set_win)  win  <= 1'b1;
      if (set_lose) lose <= 1'b1;
      if (set_tie)  tie  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    p_load    = 1'b0;
    d_load    = 1'b0;
    set_win   = 1'b0;
    set_lose  = 1'b0;
    set_tie   = 1'b0;
    dhit      = (state == D_REQ);
    dstay     = (state == DONE);
    case (state)
      DEAL_P0: if (hit && card_ok) begin p_load = 1'b1; state_nxt = DEAL_D0; end
      DEAL_D0: if (hit && card_ok) begin d_load = 1'b1; state_nxt = DEAL_P1; end
      DEAL_P1: if (hit && card_ok) begin p_load = 1'b1; state_nxt = DEAL_D1; end
      DEAL_D1: if (hit && card_ok) begin d_load = 1'b1; state_nxt = CHECK;   end
      CHECK: begin
        if (p_e > TGT) begin
          set_lose  = 1'b1;
          state_nxt = DONE;
        end else if (d_e > TGT) begin
          set_win   = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = PLAYER;
        end
      end
      PLAYER: begin
        // Stay wins over a simultaneous hit; a busting hit ends the game at once.
        if (stay) begin
          state_nxt = D_EVAL;
        end else if (hit && card_ok) begin
          p_load = 1'b1;
          if (EW'(p_add) > TGT) begin
            set_lose  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      D_EVAL: begin
        if (d_e > TGT) begin
          set_win   = 1'b1;
          state_nxt = DONE;
        end else if (d_e >= STAND) begin
          set_win   = (p_e > d_e);
          set_lose  = (p_e < d_e);
          set_tie   = (p_e == d_e);
          state_nxt = DONE;
        end else begin
          state_nxt = D_REQ;
        end
      end
      D_REQ: if (card_ok) begin d_load = 1'b1; state_nxt = D_EVAL; end
      DONE:    state_nxt = DONE;
      default: state_nxt = DEAL_P0;
    endcase
  end

endmodule

// File: tb/tb_blackjack_engine.sv
// Randomized and directed bench for blackjack_engine against a card-counting reference model.
module tb_blackjack_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       hit = 1'b0, stay = 1'b0;
  logic [3:0] card = 4'd0;
  logic       dhit, dstay, win, lose, tie;
  logic [5:0] player_sum, dealer_sum;

  int checks = 0;
  int fails  = 0;

`ifdef SOFT_ACE_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  blackjack_engine dut (
    .clock(clock), .reset(reset), .hit(hit), .stay(stay), .card(card),
    .dhit(dhit), .dstay(dstay), .win(win), .lose(lose), .tie(tie),
    .player_sum(player_sum), .dealer_sum(dealer_sum)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    hit = 1'b0; stay = 1'b0; card = 4'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic give(input int c);
    hit = 1'b1; card = 4'(c);
    tick();
    idle();
  endtask

  // Hand arithmetic straight from the game rules.
  task automatic madd(input int tot_i, input bit soft_i, input int c,
                      output int tot_o, output bit soft_o);
    int v;
    v = (c > 11) ? 11 : c;
    tot_o = tot_i; soft_o = soft_i;
    if (SOFT && v == 1 && tot_i + 11 <= 21) begin
      tot_o = tot_i + 11; soft_o = 1'b1;
    end else begin
      tot_o = tot_i + v;
    end
    if (soft_o && tot_o > 21) begin
      tot_o -= 10; soft_o = 1'b0;
    end
    if (tot_o > 63) tot_o = 63;
  endtask

  task automatic wait_done(output bit seen_dhit, output bit timed_out);
    seen_dhit = 1'b0; timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (dhit) seen_dhit = 1'b1;
      if (dstay) begin timed_out = 1'b0; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({dhit, dstay, win, lose, tie, player_sum, dealer_sum} !== 17'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required all zero",
               {dhit, dstay, win, lose, tie, player_sum, dealer_sum});
    end
  endtask

  task automatic test_player_stands_21();
    int hl[9] = '{1, 1, 2, 2, 2, 2, 3, 3, 3};
    bit seen, to;
    do_reset();
    give(1); give(9); give(1); give(9);
    tick();
    for (int i = 0; i < 9; i++) give(hl[i]);
    stay = 1'b1; tick(); stay = 1'b0;
    wait_done(seen, to);
    checks++;
    if (to || seen || player_sum !== 6'd21 || dealer_sum !== 6'd18) begin
      fails++;
      $display("FAIL stand21_sums: got p=%0d d=%0d dhit=%0b timeout=%0b required p=21 d=18 dhit=0 timeout=0",
               player_sum, dealer_sum, seen, to);
    end
    checks++;
    if ({dstay, win, lose, tie} !== 4'b1100) begin
      fails++;
      $display("FAIL stand21_result: got dstay/w/l/t=%b required 1100", {dstay, win, lose, tie});
    end
  endtask

  task automatic test_dealer_bust_on_deal();
    do_reset();
    give(10); give(11); give(11); give(11);
    checks++;
    if (dstay !== 1'b0 || dealer_sum !== 6'd22) begin
      fails++;
      $display("FAIL deal_bust_check_cycle: got dstay=%0b d=%0d required dstay=0 d=22", dstay, dealer_sum);
    end
    tick();
    checks++;
    if ({dstay, win, lose, tie} !== 4'b1100 || player_sum !== 6'd21) begin
      fails++;
      $display("FAIL deal_bust_result: got dstay/w/l/t=%b p=%0d required 1100 p=21",
               {dstay, win, lose, tie}, player_sum);
    end
    give(5);
    checks++;
    if (player_sum !== 6'd21) begin
      fails++;
      $display("FAIL deal_bust_no_player: got p=%0d required 21", player_sum);
    end
  endtask

  task automatic test_dealer_draw_tie();
    int pulses = 0;
    do_reset();
    give(9); give(7); give(8); give(9);
    tick();
    stay = 1'b1; tick(); stay = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dstay) break;
      if (dhit) begin pulses++; card = 4'd1; end
      else card = 4'd0;
      tick();
    end
    card = 4'd0;
    checks++;
    if (pulses != 1 || dealer_sum !== 6'd17) begin
      fails++;
      $display("FAIL draw_tie_pulse: got pulses=%0d d=%0d required pulses=1 d=17", pulses, dealer_sum);
    end
    checks++;
    if ({dstay, win, lose, tie} !== 4'b1001) begin
      fails++;
      $display("FAIL draw_tie_result: got dstay/w/l/t=%b required 1001", {dstay, win, lose, tie});
    end
  endtask

  task automatic test_player_bust();
    bit seen = 1'b0;
    logic [16:0] snap;
    do_reset();
    give(5); give(3); give(5); give(4);
    tick();
    give(7);
    checks++;
    if (player_sum !== 6'd17) begin
      fails++;
      $display("FAIL bust_first_hit: got p=%0d required 17", player_sum);
    end
    give(10);
    if (dhit) seen = 1'b1;
    checks++;
    if (player_sum !== 6'd27) begin
      fails++;
      $display("FAIL bust_sum: got p=%0d required 27", player_sum);
    end
    tick();
    if (dhit) seen = 1'b1;
    checks++;
    if ({dstay, win, lose, tie} !== 4'b1010 || seen) begin
      fails++;
      $display("FAIL bust_result: got dstay/w/l/t=%b dhit=%0b required 1010 dhit=0", {dstay, win, lose, tie}, seen);
    end
    snap = {dhit, dstay, win, lose, tie, player_sum, dealer_sum};
    give(3);
    stay = 1'b1; tick(); stay = 1'b0;
    checks++;
    if ({dhit, dstay, win, lose, tie, player_sum, dealer_sum} !== snap) begin
      fails++;
      $display("FAIL done_ignores_inputs: got %b required %b",
               {dhit, dstay, win, lose, tie, player_sum, dealer_sum}, snap);
    end
  endtask

  task automatic test_edges();
    do_reset();
    hit = 1'b1; card = 4'd0;
    tick(); tick(); tick();
    idle();
    checks++;
    if (player_sum !== 6'd0 || dealer_sum !== 6'd0) begin
      fails++;
      $display("FAIL zero_card_hold: got p=%0d d=%0d required 0 0", player_sum, dealer_sum);
    end
    give(15);
    give(6);
    checks++;
    if (player_sum !== 6'd11 || dealer_sum !== 6'd6) begin
      fails++;
      $display("FAIL clamp_and_advance: got p=%0d d=%0d required p=11 d=6", player_sum, dealer_sum);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    give(4);
    checks++;
    if (player_sum !== 6'd4 || dealer_sum !== 6'd0) begin
      fails++;
      $display("FAIL first_card_after_reset: got p=%0d d=%0d required p=4 d=0", player_sum, dealer_sum);
    end
    give(5); give(5); give(5);
    tick();
    hit = 1'b1; stay = 1'b1; card = 4'd3;
    tick();
    idle();
    checks++;
    if (player_sum !== 6'd9) begin
      fails++;
      $display("FAIL stay_priority: got p=%0d required 9", player_sum);
    end
    tick();
    checks++;
    if (dhit !== 1'b1) begin
      fails++;
      $display("FAIL dealer_request: got dhit=%0b required 1", dhit);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if ({dhit, dstay, win, lose, tie, player_sum, dealer_sum} !== 17'd0) begin
      fails++;
      $display("FAIL reset_mid_dreq: got %b required all zero",
               {dhit, dstay, win, lose, tie, player_sum, dealer_sum});
    end
  endtask

  task automatic test_soft_ace();
    bit seen, to;
    int exp_p;
    logic [3:0] exp_r;
    exp_p = SOFT ? 21 : 11;
    exp_r = SOFT ? 4'b1100 : 4'b1010;
    do_reset();
    give(1); give(9); give(10); give(9);
    tick();
    stay = 1'b1; tick(); stay = 1'b0;
    wait_done(seen, to);
    checks++;
    if (to || player_sum !== 6'(exp_p) || {dstay, win, lose, tie} !== exp_r) begin
      fails++;
      $display("FAIL soft_ace: got p=%0d dstay/w/l/t=%b timeout=%0b required p=%0d %b",
               player_sum, {dstay, win, lose, tie}, to, exp_p, exp_r);
    end
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 60; g++) begin
      int pt = 0, dt = 0, c, nh;
      bit ps = 0, ds = 0, seen, to, resolved = 0, no_dhit = 0;
      logic [2:0] exp_r = 3'b000;
      do_reset();
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          hit = 1'($urandom_range(0, 1));
          card = hit ? 4'd0 : 4'($urandom_range(1, 15));
          tick();
          idle();
        end
        c = $urandom_range(1, 15);
        give(c);
        if (k % 2 == 0) madd(pt, ps, c, pt, ps);
        else            madd(dt, ds, c, dt, ds);
      end
      checks++;
      if (player_sum !== 6'(pt) || dealer_sum !== 6'(dt)) begin
        fails++;
        $display("FAIL rand_deal g%0d: got p=%0d d=%0d required p=%0d d=%0d", g, player_sum, dealer_sum, pt, dt);
      end
      tick();
      if (pt > 21)      begin exp_r = 3'b010; resolved = 1; no_dhit = 1; end
      else if (dt > 21) begin exp_r = 3'b100; resolved = 1; no_dhit = 1; end
      if (!resolved) begin
        nh = $urandom_range(0, 4);
        for (int i = 0; i < nh; i++) begin
          c = $urandom_range(0, 15);
          give(c);
          if (c != 0) madd(pt, ps, c, pt, ps);
          checks++;
          if (player_sum !== 6'(pt)) begin
            fails++;
            $display("FAIL rand_hit g%0d: got p=%0d required %0d", g, player_sum, pt);
          end
          if (pt > 21) break;
        end
        if (pt > 21) begin
          exp_r = 3'b010; no_dhit = 1;
          tick();
        end else begin
          stay = 1'b1; tick(); stay = 1'b0;
          for (int i = 0; i < 80; i++) begin
            if (dstay) break;
            if (dhit) begin
              checks++;
              if (dt >= 17) begin
                fails++;
                $display("FAIL rand_dealer_overdraw g%0d: got dhit=1 at d=%0d required dhit=0", g, dt);
              end
              c = $urandom_range(0, 15);
              card = 4'(c);
              tick();
              card = 4'd0;
              if (c != 0) madd(dt, ds, c, dt, ds);
            end else begin
              tick();
            end
          end
          if (dt > 21)       exp_r = 3'b100;
          else if (pt > dt)  exp_r = 3'b100;
          else if (pt < dt)  exp_r = 3'b010;
          else               exp_r = 3'b001;
        end
      end
      wait_done(seen, to);
      checks++;
      if (to || {win, lose, tie} !== exp_r || (no_dhit && seen)) begin
        fails++;
        $display("FAIL rand_result g%0d: got w/l/t=%b timeout=%0b dhit=%0b required %b", g,
                 {win, lose, tie}, to, seen, exp_r);
      end
      checks++;
      if (player_sum !== 6'(pt) || dealer_sum !== 6'(dt)) begin
        fails++;
        $display("FAIL rand_final_sums g%0d: got p=%0d d=%0d required p=%0d d=%0d", g,
                 player_sum, dealer_sum, pt, dt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_player_stands_21();
    test_dealer_bust_on_deal();
    test_dealer_draw_tie();
    test_player_bust();
    test_edges();
    test_soft_ace();
    test_random_games();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
